// File: rtl/enc_lag_param_pkg.sv
// Shared types, scratch addresses and small helpers for the parametrised G.729 pitch-lag encoder.
package enc_lag_param_pkg;

    // Channel 0 search-window word addresses, mirroring the shared scratch address list.
    localparam int T0_MIN = 'h100;
    localparam int T0_MAX = 'h101;

    localparam logic [15:0] FRAC_NEG1 = 16'hFFFF;

    typedef enum logic [3:0] {
        IDLE,
        CALC1,
        WR_MIN,
        WR_MAX,
        RD_MIN,
        RD_MAX,
        WAIT_RD,
        CALC2,
        DONE
    } state_t;

    function automatic logic [15:0] clamp16(
        input logic [15:0] value,
        input logic [15:0] lo,
        input logic [15:0] hi
    );
        logic [15:0] result;
        result = value;
        if (value < lo) begin
            result = lo;
        end else if (value > hi) begin
            result = hi;
        end
        return result;
    endfunction

    function automatic logic frac_legal(input logic [15:0] frac);
        return (frac == FRAC_NEG1) || (frac == 16'd0) || (frac == 16'd1);
    endfunction

endpackage

// File: rtl/enc_lag_param_calc.sv
// Combinational lag clamp, codebook index formula and next search-window computation.
module lag_index_calc
    import enc_lag_param_pkg::*;
#(
    parameter int PIT_MIN  = 20,
    parameter int PIT_MAX  = 143,
    parameter int FRAC_THR = 85,
    parameter int WIN_LO   = 5,
    parameter int WIN_LEN  = 9
) (
    input  logic        sub2,
    input  logic [15:0] t0,
    input  logic [15:0] frac,
    input  logic [15:0] bound_lo,
    input  logic [15:0] bound_hi,
    output logic [15:0] index,
    output logic        range_err,
    output logic [15:0] win_min,
    output logic [15:0] win_max
);

    localparam logic [15:0] P_MIN     = 16'(PIT_MIN);
    localparam logic [15:0] P_MAX     = 16'(PIT_MAX);
    localparam logic [15:0] F_THR     = 16'(FRAC_THR);
    localparam logic [15:0] W_LO      = 16'(WIN_LO);
    localparam logic [15:0] W_LEN     = 16'(WIN_LEN);
    localparam logic [15:0] WIN_FLOOR = 16'(PIT_MIN + WIN_LO);
    localparam logic [15:0] OFS_FINE  = 16'(3 * PIT_MIN - 2);
    localparam logic [15:0] OFS_COARSE = 16'(2 * FRAC_THR - 3 * PIT_MIN + 2);

    logic        frac_ok;
    logic [15:0] frac_eff;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [15:0] tc;

    always_comb begin
        frac_ok   = frac_legal(frac);
        frac_eff  = frac_ok ? frac : 16'd0;
        lo        = sub2 ? bound_lo : P_MIN;
        hi        = sub2 ? bound_hi : P_MAX;
        tc        = clamp16(t0, lo, hi);
        range_err = (t0 < lo) || (t0 > hi) || !frac_ok;

        if (sub2) begin
            index = 16'd3 * (tc - lo) + 16'd2 + frac_eff;
        end else if (tc <= F_THR) begin
            index = 16'd3 * tc - OFS_FINE + frac_eff;
        end else begin
            index = tc + OFS_COARSE;
        end
    end

    // Window is anchored below Tc, then slid down if it would overrun the top lag.
    always_comb begin
        win_min = (tc < WIN_FLOOR) ? P_MIN : (tc - W_LO);
        win_max = win_min + W_LEN;
        if (win_max > P_MAX) begin
            win_max = P_MAX;
            win_min = P_MAX - W_LEN;
        end
    end

endmodule

// File: rtl/enc_lag_param.sv
// Pitch-lag encoder top: captures a request, sequences the per-channel window words in scratch
// memory and registers the encoded index.
module enc_lag_param
    import enc_lag_param_pkg::*;
#(
    parameter int PIT_MIN   = 20,
    parameter int PIT_MAX   = 143,
    parameter int FRAC_THR  = 85,
    parameter int WIN_LO    = 5,
    parameter int WIN_LEN   = 9,
    parameter int NUM_CH    = 1,
    parameter int ADDR_W    = 12,
    parameter int MEM_W     = 32,
    parameter int MIN_BASE  = T0_MIN,
    parameter int MAX_BASE  = T0_MAX,
    parameter int CH_STRIDE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        ch,
    input  logic [15:0]       T0,
    input  logic [15:0]       T0_frac,
    input  logic [15:0]       pit_flag,
    input  logic [MEM_W-1:0]  memOut,
    output logic [ADDR_W-1:0] memReadAddr,
    output logic [ADDR_W-1:0] memWriteAddr,
    output logic [MEM_W-1:0]  memIn,
    output logic              memWriteEn,
    output logic [15:0]       index,
    output logic              range_err,
    output logic              done
);

    state_t      state;
    state_t      next_state;
    logic [1:0]  ch_q;
    logic [15:0] t0_q;
    logic [15:0] frac_q;
    logic        sub2_q;
    logic [15:0] lo_q;
    logic [15:0] hi_q;
    logic [1:0]  ch_sel;
    logic [15:0] calc_index;
    logic        calc_err;
    logic [15:0] calc_win_min;
    logic [15:0] calc_win_max;
    logic        unused_mem_hi;

    function automatic logic [ADDR_W-1:0] min_addr(input logic [1:0] c);
        return ADDR_W'(MIN_BASE + int'(c) * CH_STRIDE);
    endfunction

    function automatic logic [ADDR_W-1:0] max_addr(input logic [1:0] c);
        return ADDR_W'(MAX_BASE + int'(c) * CH_STRIDE);
    endfunction

    // Channels beyond the configured count fold onto channel 0.
    assign ch_sel        = (int'(ch) < NUM_CH) ? ch : 2'd0;
    assign unused_mem_hi = ^memOut[MEM_W-1:16];

    lag_index_calc #(
        .PIT_MIN  (PIT_MIN),
        .PIT_MAX  (PIT_MAX),
        .FRAC_THR (FRAC_THR),
        .WIN_LO   (WIN_LO),
        .WIN_LEN  (WIN_LEN)
    ) u_calc (
        .sub2      (sub2_q),
        .t0        (t0_q),
        .frac      (frac_q),
        .bound_lo  (lo_q),
        .bound_hi  (hi_q),
        .index     (calc_index),
        .range_err (calc_err),
        .win_min   (calc_win_min),
        .win_max   (calc_win_max)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (pit_flag != 16'd0) ? RD_MIN : CALC1;
                end
            end
            CALC1:   next_state = WR_MIN;
            WR_MIN:  next_state = WR_MAX;
            WR_MAX:  next_state = DONE;
            RD_MIN:  next_state = RD_MAX;
            RD_MAX:  next_state = WAIT_RD;
            WAIT_RD: next_state = CALC2;
            CALC2:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory strobes and results are registered on the edge entering the state that owns them,
    // so memWriteEn is high exactly during WR_MIN and WR_MAX.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            ch_q         <= 2'd0;
            t0_q         <= 16'd0;
            frac_q       <= 16'd0;
            sub2_q       <= 1'b0;
            lo_q         <= 16'd0;
            hi_q         <= 16'd0;
            memReadAddr  <= '0;
            memWriteAddr <= '0;
            memIn        <= '0;
            memWriteEn   <= 1'b0;
            index        <= 16'd0;
            range_err    <= 1'b0;
            done         <= 1'b0;
        end else begin
            state      <= next_state;
            memWriteEn <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ch_q   <= ch_sel;
                        t0_q   <= T0;
                        frac_q <= T0_frac;
                        sub2_q <= (pit_flag != 16'd0);
                        done   <= 1'b0;
                        if (pit_flag != 16'd0) begin
                            memReadAddr <= min_addr(ch_sel);
                        end
                    end
                end
                CALC1: begin
                    index        <= calc_index;
                    range_err    <= calc_err;
                    lo_q         <= calc_win_min;
                    hi_q         <= calc_win_max;
                    memWriteEn   <= 1'b1;
                    memWriteAddr <= min_addr(ch_q);
                    memIn        <= MEM_W'(calc_win_min);
                end
                WR_MIN: begin
                    memWriteEn   <= 1'b1;
                    memWriteAddr <= max_addr(ch_q);
                    memIn        <= MEM_W'(hi_q);
                end
                WR_MAX: begin
                    done <= 1'b1;
                end
                RD_MIN: begin
                    memReadAddr <= max_addr(ch_q);
                end
                RD_MAX: begin
                    lo_q <= memOut[15:0];
                end
                WAIT_RD: begin
                    hi_q <= memOut[15:0];
                end
                CALC2: begin
                    index     <= calc_index;
                    range_err <= calc_err;
                    done      <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
